// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// load_store_unit : RV32 load/store sequencer in front of D_memory.
// Optional MISALIGN_SPLIT_EN splits word-crossing misaligned accesses in two.
// Revision: 1.0
// =============================================================================

package controls;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op;
endpackage

module load_store_unit
  import controls::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int WORD_SIZE = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  mem_op                req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam logic [1:0] c_wait_init = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  function automatic logic [2:0] op_bytes(input mem_op op);
    case (op)
      LB, LBU, SB: op_bytes = 3'd1;
      LH, LHU, SH: op_bytes = 3'd2;
      default:     op_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input mem_op op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  state_t               r_state, w_next;
  mem_op                r_op;
  logic [ADDR_BITS-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_split, r_second;
  logic [1:0]           r_cnt;
  logic [WORD_SIZE-1:0] r_lo;

  logic [2:0] w_req_bytes;
  logic       w_req_misal, w_req_bad, w_req_split;

  assign w_req_bytes = op_bytes(req_op);
  assign w_req_misal = ((w_req_bytes == 3'd2) && req_addr[0]) ||
                       ((w_req_bytes == 3'd4) && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_SPLIT_EN
  logic w_req_cross;
  assign w_req_cross = (({1'b0, req_addr[1:0]} + w_req_bytes) > 3'd4);
  assign w_req_bad   = 1'b0;
  assign w_req_split = w_req_misal && w_req_cross;
`else
  assign w_req_bad   = w_req_misal;
  assign w_req_split = 1'b0;
`endif

  // Access fields come from the live request on the first access, else from the held copy
  logic                   w_first, w_load_mem, w_capture, w_r_store;
  mem_op                  w_src_op;
  logic [ADDR_BITS-1:0]   w_src_addr, w_acc_addr;
  logic [WORD_SIZE-1:0]   w_src_wdata, w_src_wmask, w_acc_wdata;
  logic [7:0]             w_be8;
  logic [3:0]             w_acc_be;
  logic [2*WORD_SIZE-1:0] w_wd64;

  assign w_first     = (r_state == IDLE);
  assign w_src_op    = w_first ? req_op : r_op;
  assign w_src_addr  = w_first ? req_addr : r_addr;
  assign w_src_wdata = w_first ? req_wdata : r_wdata;
  assign w_r_store   = is_store(r_op);

  always_comb begin
    w_be8       = 8'h0F;
    w_src_wmask = w_src_wdata;
    case (op_bytes(w_src_op))
      3'd1: begin
        w_be8       = 8'h01;
        w_src_wmask = {{(WORD_SIZE-8){1'b0}}, w_src_wdata[7:0]};
      end
      3'd2: begin
        w_be8       = 8'h03;
        w_src_wmask = {{(WORD_SIZE-16){1'b0}}, w_src_wdata[15:0]};
      end
      default: ;
    endcase
    w_be8 = w_be8 << w_src_addr[1:0];
  end

  assign w_wd64      = {{WORD_SIZE{1'b0}}, w_src_wmask} << {w_src_addr[1:0], 3'b000};
  assign w_acc_addr  = {w_src_addr[ADDR_BITS-1:2], 2'b00} + (w_first ? '0 : ADDR_BITS'(4));
  assign w_acc_be    = !is_store(w_src_op) ? 4'hF : (w_first ? w_be8[3:0] : w_be8[7:4]);
  assign w_acc_wdata = !is_store(w_src_op) ? '0 :
                       (w_first ? w_wd64[WORD_SIZE-1:0] : w_wd64[2*WORD_SIZE-1:WORD_SIZE]);

  // Load merge: the low word is the held first read on a split, else the current read
  logic [WORD_SIZE-1:0] w_lo, w_rd, w_ext;
  assign w_lo = r_second ? r_lo : mem_rdata;
  assign w_rd = WORD_SIZE'({mem_rdata, w_lo} >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_ext = w_rd;
    case (r_op)
      LB:      w_ext = {{(WORD_SIZE-8){w_rd[7]}}, w_rd[7:0]};
      LH:      w_ext = {{(WORD_SIZE-16){w_rd[15]}}, w_rd[15:0]};
      LBU:     w_ext = {{(WORD_SIZE-8){1'b0}}, w_rd[7:0]};
      LHU:     w_ext = {{(WORD_SIZE-16){1'b0}}, w_rd[15:0]};
      default: w_ext = w_rd;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_load_mem = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_bad) begin
            w_next = RESP;
          end else begin
            w_next     = ACC0;
            w_load_mem = 1'b1;
          end
        end
      end
      ACC0: begin
        if (!w_r_store) begin
          w_next = WAIT;
        end else if (r_split) begin
          w_next     = ACC1;
          w_load_mem = 1'b1;
        end else begin
          w_next = RESP;
        end
      end
      ACC1: w_next = w_r_store ? RESP : WAIT;
      WAIT: begin
        if (r_cnt == 2'd0) begin
          w_capture = 1'b1;
          if (r_split && !r_second) begin
            w_next     = ACC1;
            w_load_mem = 1'b1;
          end else begin
            w_next = RESP;
          end
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= LB;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_split    <= 1'b0;
      r_second   <= 1'b0;
      r_cnt      <= 2'd0;
      r_lo       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'h0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_op     <= req_op;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_split  <= w_req_split;
        r_second <= 1'b0;
      end
      if (w_next == ACC1) r_second <= 1'b1;
      if (w_load_mem) begin
        mem_we    <= is_store(w_src_op);
        mem_addr  <= w_acc_addr;
        mem_be    <= w_acc_be;
        mem_wdata <= w_acc_wdata;
      end
      if (w_next == WAIT && r_state != WAIT) r_cnt <= c_wait_init;
      else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (w_capture && !r_second) r_lo <= mem_rdata;
      // Response payload is live only during RESP
      if (r_state == RESP) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end else if (w_next == RESP) begin
        resp_err   <= (r_state == IDLE);
        resp_rdata <= (r_state == WAIT) ? w_ext : '0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign mem_req    = (r_state == ACC0) || (r_state == ACC1);
  assign resp_valid = (r_state == RESP);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// =============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit.
// Revision: 1.0
// =============================================================================

module tb_load_store_unit;
  import controls::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_op       req_op = LB;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_BITS(32), .WORD_SIZE(32), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, byte-enabled writes, bench preload port
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] = pl_data;
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:2]];
      end
    end
  end

  int          n_req, resp_cyc, rdy_hi;
  logic [31:0] a0, a1, wd0, r_data;
  logic [3:0]  be0;
  logic        we0, r_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issue one request and log mem_req pulses and the response, up to 20 cycles after accept
  task automatic run_req(input mem_op op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic hold);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
    n_req = 0; resp_cyc = 0; rdy_hi = 0;
    a0 = '0; a1 = '0; wd0 = '0; be0 = '0; we0 = 1'b0; r_data = 'x; r_err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (req_ready) rdy_hi++;
      if (mem_req) begin
        if (n_req == 0) begin
          a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
        end else begin
          a1 = mem_addr;
        end
        n_req++;
      end
      if (resp_valid) begin
        resp_cyc = k; r_data = resp_rdata; r_err = resp_err;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int late_resp;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);

    preload(4'd0, 32'h0000_0000);
    preload(4'd1, 32'h8899_AABB);
    @(negedge clk) rst_n = 1'b1;

    run_req(LB, 32'h5, 32'h0, 1'b0);
    chk("lb5_nreq", 32'(n_req), 32'd1);
    chk("lb5_addr", a0, 32'h4);
    chk("lb5_we", 32'(we0), 32'd0);
    chk("lb5_be", 32'(be0), 32'hF);
    chk("lb5_cyc", 32'(resp_cyc), 32'd3);
    chk("lb5_rdata", r_data, 32'hFFFF_FFAA);
    chk("lb5_err", 32'(r_err), 32'd0);

    run_req(LHU, 32'h6, 32'h0, 1'b0);
    chk("lhu6_cyc", 32'(resp_cyc), 32'd3);
    chk("lhu6_rdata", r_data, 32'h0000_8899);

    run_req(LH, 32'h6, 32'h0, 1'b0);
    chk("lh6_rdata", r_data, 32'hFFFF_8899);

    run_req(SB, 32'h1, 32'h0000_022B, 1'b0);
    chk("sb1_nreq", 32'(n_req), 32'd1);
    chk("sb1_addr", a0, 32'h0);
    chk("sb1_be", 32'(be0), 32'h2);
    chk("sb1_wdata", wd0, 32'h0000_2B00);
    chk("sb1_we", 32'(we0), 32'd1);
    chk("sb1_cyc", 32'(resp_cyc), 32'd2);
    chk("sb1_rdata", r_data, 32'h0);

    run_req(LBU, 32'h1, 32'h0, 1'b0);
    chk("lbu1_rdata", r_data, 32'h0000_002B);

    run_req(SH, 32'h2, 32'hABCD_1234, 1'b0);
    chk("sh2_be", 32'(be0), 32'hC);
    chk("sh2_wdata", wd0, 32'h1234_0000);
    run_req(LW, 32'h0, 32'h0, 1'b0);
    chk("lw0_rdata", r_data, 32'h1234_2B00);

    run_req(SW, 32'h8, 32'hDEAD_BEEF, 1'b0);
    chk("sw8_be", 32'(be0), 32'hF);
    run_req(LB, 32'hB, 32'h0, 1'b0);
    chk("lbb_rdata", r_data, 32'hFFFF_FFDE);

`ifdef MISALIGN_SPLIT_EN
    preload(4'd0, 32'h4433_2211);
    preload(4'd1, 32'h8877_6655);
    run_req(LW, 32'h2, 32'h0, 1'b0);
    chk("lw2s_nreq", 32'(n_req), 32'd2);
    chk("lw2s_addr0", a0, 32'h0);
    chk("lw2s_be0", 32'(be0), 32'hF);
    chk("lw2s_addr1", a1, 32'h4);
    chk("lw2s_cyc", 32'(resp_cyc), 32'd5);
    chk("lw2s_rdata", r_data, 32'h6655_4433);
    chk("lw2s_err", 32'(r_err), 32'd0);
    preload(4'd1, 32'h8899_AABB);
`else
    run_req(LW, 32'h2, 32'h0, 1'b0);
    chk("lw2_nreq", 32'(n_req), 32'd0);
    chk("lw2_cyc", 32'(resp_cyc), 32'd1);
    chk("lw2_err", 32'(r_err), 32'd1);
    chk("lw2_rdata", r_data, 32'h0);
`endif

    run_req(SB, 32'h3, 32'h0000_0055, 1'b1);
    chk("hold_nreq", 32'(n_req), 32'd1);
    chk("hold_cyc", 32'(resp_cyc), 32'd2);
    chk("hold_ready_busy", 32'(rdy_hi), 32'd0);
    @(negedge clk);
    chk("hold_ready_after", 32'(req_ready), 32'd1);
    chk("hold_no_second", 32'(mem_req), 32'd0);

    // Abort a load while it sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_op = LW; req_addr = 32'h4; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    late_resp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) late_resp++;
    end
    chk("rstw_no_stale", 32'(late_resp), 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd1);

    run_req(LB, 32'h4, 32'h0, 1'b0);
    chk("post_rst_rdata", r_data, 32'hFFFF_FFBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
